// File: rtl/matrix_loader.sv
// matrix_loader: loads A/B from byte memory into the ALU, runs it, writes the result back (MATRIX_LOADER_UNARY_SKIP_EN skips B for unary ops)
module matrix_loader #(
    parameter int ELEMS  = 25,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [3:0]              cmd_opcode,
    input  logic [ADDR_W-1:0]       cmd_addr_a,
    input  logic [ADDR_W-1:0]       cmd_addr_b,
    input  logic [ADDR_W-1:0]       cmd_addr_r,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_rd_en,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    mem_wr_en,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [3:0]              alu_opcode,
    output logic [ELEMS*DATA_W-1:0] alu_matrizA,
    output logic [ELEMS*DATA_W-1:0] alu_matrizB,
    output logic                    alu_start,
    input  logic [ELEMS*DATA_W-1:0] alu_result,
    input  logic                    alu_done,
    output logic                    busy,
    output logic                    cmd_done
);
    localparam int MW = ELEMS * DATA_W;
    localparam int CW = $clog2(2 * ELEMS);
    typedef enum logic [2:0] {IDLE, LOAD, EXEC, STORE, FIN} state_t;
    state_t state;
    logic [ADDR_W-1:0] addr_b, addr_r;
    logic [CW-1:0] k, last;
    logic cap_en, cap_b, skip;
    logic [MW-1:0] res;
`ifdef MATRIX_LOADER_UNARY_SKIP_EN
    assign skip = alu_opcode == 4'b0110 || alu_opcode == 4'b0111;
`else
    assign skip = 1'b0;
`endif
    assign last      = skip ? CW'(ELEMS - 1) : CW'(2 * ELEMS - 1);
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    // operands fill by shifting in from the top, so the first byte read ends up in element 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_b      <= '0;
            addr_r      <= '0;
            k           <= '0;
            cap_en      <= 1'b0;
            cap_b       <= 1'b0;
            res         <= '0;
            mem_addr    <= '0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wdata   <= '0;
            alu_opcode  <= '0;
            alu_matrizA <= '0;
            alu_matrizB <= '0;
            alu_start   <= 1'b0;
            cmd_done    <= 1'b0;
        end else begin
            cap_en <= mem_rd_en;
            cap_b  <= k >= CW'(ELEMS);
            if (cap_en && cap_b) alu_matrizB <= {mem_rdata, alu_matrizB[MW-1:DATA_W]};
            if (cap_en && !cap_b) alu_matrizA <= {mem_rdata, alu_matrizA[MW-1:DATA_W]};
            case (state)
                IDLE: if (cmd_valid) begin
                    state      <= LOAD;
                    alu_opcode <= cmd_opcode;
                    addr_b     <= cmd_addr_b;
                    addr_r     <= cmd_addr_r;
                    mem_addr   <= cmd_addr_a;
                    mem_rd_en  <= 1'b1;
                    k          <= '0;
                end
                LOAD: if (mem_rd_en) begin
                    if (k == last) mem_rd_en <= 1'b0;
                    else begin
                        k        <= k + 1'b1;
                        mem_addr <= k == CW'(ELEMS - 1) ? addr_b : mem_addr + 1'b1;
                    end
                end else if (cap_en) begin
                    state     <= EXEC;
                    alu_start <= 1'b1;
                    if (skip) alu_matrizB <= '0;
                end
                EXEC: if (alu_done) begin
                    state     <= STORE;
                    alu_start <= 1'b0;
                    res       <= alu_result >> DATA_W;
                    mem_wr_en <= 1'b1;
                    mem_addr  <= addr_r;
                    mem_wdata <= alu_result[DATA_W-1:0];
                    k         <= '0;
                end
                STORE: if (k == CW'(ELEMS - 1)) begin
                    state     <= FIN;
                    mem_wr_en <= 1'b0;
                    cmd_done  <= 1'b1;
                end else begin
                    k         <= k + 1'b1;
                    mem_addr  <= mem_addr + 1'b1;
                    mem_wdata <= res[DATA_W-1:0];
                    res       <= res >> DATA_W;
                end
                FIN: begin
                    state    <= IDLE;
                    cmd_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: randomized bench with memory/ALU models and a reference of the expected memory image
module tb_matrix_loader;
`ifdef MATRIX_LOADER_UNARY_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic cmd_valid, cmd_ready, mem_rd_en, mem_wr_en, alu_start, alu_done, busy, cmd_done;
    logic [3:0] cmd_opcode, alu_opcode;
    logic [7:0] cmd_addr_a, cmd_addr_b, cmd_addr_r, mem_addr, mem_rdata, mem_wdata;
    logic [199:0] alu_matrizA, alu_matrizB, alu_result;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] sa [25];
    logic [7:0] sb [25];
    int alu_lat = 1, alu_cnt, checks = 0, errs = 0;

    matrix_loader dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b),
        .cmd_addr_r(cmd_addr_r), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .alu_opcode(alu_opcode), .alu_matrizA(alu_matrizA), .alu_matrizB(alu_matrizB),
        .alu_start(alu_start), .alu_result(alu_result), .alu_done(alu_done),
        .busy(busy), .cmd_done(cmd_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] op_elem(input logic [3:0] op, input logic [7:0] a [25],
                                           input logic [7:0] b [25], input int i);
        case (op)
            4'b0011: return a[i] + b[i];
            4'b0110: return a[(i % 5) * 5 + i / 5];
            4'b0111: return 8'(-a[i]);
            default: return a[i] - b[i];
        endcase
    endfunction

    function automatic logic [199:0] pack(input logic [7:0] e [25]);
        logic [199:0] v = '0;
        for (int i = 0; i < 25; i++) v[8*i +: 8] = e[i];
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    end

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            alu_done <= 1'b0;
            alu_cnt  <= 0;
        end else if (!alu_start) begin
            alu_done <= 1'b0;
            alu_cnt  <= 0;
        end else if (!alu_done) begin
            alu_cnt <= alu_cnt + 1;
            if (alu_cnt + 1 >= alu_lat) alu_done <= 1'b1;
        end

    always_comb
        for (int i = 0; i < 25; i++) begin
            sa[i] = alu_matrizA[8*i +: 8];
            sb[i] = alu_matrizB[8*i +: 8];
        end

    always_comb
        for (int i = 0; i < 25; i++) alu_result[8*i +: 8] = op_elem(alu_opcode, sa, sb, i);

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_start", alu_start, 0);
        check("rst_done", cmd_done, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_opcode", alu_opcode, 0);
        check("rst_matA", alu_matrizA, 0);
        check("rst_matB", alu_matrizB, 0);
    endtask

    task automatic check_mem();
        for (int i = 0; i < 256; i++) check($sformatf("mem[%02h]", i), mem[i], ref_mem[i]);
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] r, input int lat, input bit hold, input int rst_j);
        logic [7:0] ea [25];
        logic [7:0] eb [25];
        logic [7:0] ez [25];
        logic [7:0] er [25];
        bit unary, aborted = 1'b0, finished = 1'b0;
        int n, st, rd = 0, wr = 0, wr_first = -1, st_first = -1, st_cnt = 0;
        int done_cyc = -1, done_cnt = 0, both = 0, ready_cyc = -1;
        unary = SKIP && (op == 4'b0110 || op == 4'b0111);
        n = unary ? 25 : 50;
        st = n + 2;
        for (int i = 0; i < 25; i++) begin
            ea[i] = ref_mem[8'(a + i)];
            eb[i] = ref_mem[8'(b + i)];
            ez[i] = 8'h00;
        end
        for (int i = 0; i < 25; i++) er[i] = op_elem(op, ea, eb, i);
        alu_lat = lat;
        for (int t = 0; t < 200 && !cmd_ready; t++) @(negedge clk);
        check("accept_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_addr_a = a; cmd_addr_b = b; cmd_addr_r = r;
        @(posedge clk);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (hold) begin
                cmd_opcode = 4'($urandom); cmd_addr_a = 8'($urandom);
                cmd_addr_b = 8'($urandom); cmd_addr_r = 8'($urandom);
            end else cmd_valid = 1'b0;
            if (mem_rd_en) begin
                check($sformatf("rd_addr%0d", rd), mem_addr, rd < 25 ? 8'(a + rd) : 8'(b + rd - 25));
                rd++;
            end
            if (mem_wr_en && wr == rst_j) begin
                rst_n = 1'b0;
                #1 check_reset();
                aborted = 1'b1;
                break;
            end
            if (mem_wr_en) begin
                if (wr == 0) wr_first = cyc;
                wr++;
            end
            if (mem_rd_en && mem_wr_en) both++;
            if (alu_start) begin
                if (st_cnt == 0) st_first = cyc;
                st_cnt++;
            end
            if (cmd_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cmd_ready) begin
                ready_cyc = cyc;
                finished = 1'b1;
                break;
            end
        end
        for (int j = 0; j < (aborted ? rst_j : 25); j++) ref_mem[8'(r + j)] = er[j];
        if (aborted) begin
            cmd_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("abort_wr_count", wr, rst_j);
        end else begin
            check("finished", finished, 1);
            check("rd_count", rd, n);
            check("wr_count", wr, 25);
            check("rd_wr_overlap", both, 0);
            check("start_cycle", st_first, st);
            check("start_len", st_cnt, lat + 1);
            check("wr_first", wr_first, st + lat + 1);
            check("done_cycle", done_cyc, st + lat + 26);
            check("done_pulses", done_cnt, 1);
            check("ready_cycle", ready_cyc, st + lat + 27);
            check("alu_opcode", alu_opcode, op);
            check("matA", alu_matrizA, pack(ea));
            check("matB", alu_matrizB, unary ? pack(ez) : pack(eb));
        end
        check_mem();
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_opcode = '0; cmd_addr_a = '0; cmd_addr_b = '0; cmd_addr_r = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            if (i < 25) ref_mem[i] = 8'(i + 1);
            if (i >= 8'h40 && i < 8'h59) ref_mem[i] = 8'h10;
            mem[i] <= ref_mem[i];
        end
        #1 check_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(4'b0011, 8'h00, 8'h40, 8'h80, 1, 1'b0, -1);
        for (int j = 0; j < 25; j++) check($sformatf("sum%0d", j), mem[8'h80 + j], 8'(8'h11 + j));
        run_cmd(4'b0101, 8'hF0, 8'h30, 8'hA0, 1, 1'b0, -1);
        run_cmd(4'b0011, 8'h10, 8'h50, 8'hC0, 10, 1'b0, -1);
        run_cmd(4'b0011, 8'h20, 8'h60, 8'h04, 2, 1'b1, -1);
        run_cmd(4'b0001, 8'h70, 8'h90, 8'hE0, 1, 1'b0, -1);
        run_cmd(4'b0011, 8'h00, 8'h40, 8'h80, 1, 1'b0, 10);
        run_cmd(4'b0011, 8'h00, 8'h40, 8'h80, 1, 1'b0, -1);
        run_cmd(4'b0111, 8'h30, 8'hB0, 8'hD0, 1, 1'b0, -1);
        run_cmd(4'b0110, 8'hF8, 8'h08, 8'h60, 3, 1'b0, -1);
        for (int t = 0; t < 4; t++)
            run_cmd(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(1, 5)), 1'b0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end
endmodule

// File: doc/matrix_loader.md
# matrix_loader

Sequencing stage that sits in front of the coprocessor ALU and feeds it. It accepts one command (opcode plus three byte addresses) and streams matrices A and B (25 signed 8-bit elements each) out of the byte-wide data memory into the ALU's 200-bit operand buses. It then holds the ALU `start` until `done` and writes the 200-bit result back to memory byte by byte. Only one command is in flight at a time.

## Interface
Parameters:
- `ELEMS`, 25, elements per matrix (5x5)
- `DATA_W`, 8, element width
- `ADDR_W`, 8, memory address width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  high only in IDLE
- `cmd_opcode`  in  4  ALU opcode, latched on accept
- `cmd_addr_a` / `cmd_addr_b` / `cmd_addr_r`  in  ADDR_W each  base addresses of A, B and result
- `mem_addr`  out  ADDR_W  memory address
- `mem_rd_en`  out  1  read strobe; `mem_rdata` valid exactly 1 cycle later
- `mem_rdata`  in  DATA_W  read data
- `mem_wr_en`  out  1  write strobe
- `mem_wdata`  out  DATA_W  write data
- `alu_opcode`  out  4  latched opcode
- `alu_matrizA` / `alu_matrizB`  out  200 each  operand buses; element i at bits [8i+7:8i]
- `alu_start`  out  1  level start to ALU
- `alu_result`  in  200  ALU result bus
- `alu_done`  in  1  ALU completion level
- `busy`  out  1  state != IDLE
- `cmd_done`  out  1  one-cycle pulse when write-back completes

## Operation
- FSM states: IDLE -> LOAD -> EXEC -> STORE -> FIN -> IDLE.
- IDLE: accept when `cmd_valid && cmd_ready`. Latch opcode and the three addresses. Clear counter `k`.
- LOAD: one read per cycle for k = 0..49.
  - k < 25: address `addr_a + k`.
  - k >= 25: address `addr_b + (k-25)`.
  - Data returned one cycle later is shifted into element position (k mod 25) of A or B.
  - After the last capture, go to EXEC.
- Address arithmetic is modulo 2^ADDR_W; wrap from 255 to 0 is legal and silent.
- EXEC: hold `alu_start` high until `alu_done` is sampled high. On that edge, latch `alu_result` into the result register, drop `alu_start` and go to STORE. EXEC waits indefinitely, with no timeout.
- STORE: write element j (j = 0..24) to `addr_r + j`, one per cycle, with `mem_wdata` = result[8j+7:8j].
- FIN: pulse `cmd_done` for one cycle, then return to IDLE.
- `alu_matrizA`/`alu_matrizB` hold their values from the end of LOAD until the next accepted command.
- `cmd_valid` outside IDLE is ignored; it is not queued.
- `mem_rd_en` and `mem_wr_en` are never high in the same cycle.

## Timing
- Reset (async, any state): state = IDLE.
  - `cmd_ready`=1.
  - `busy`, `mem_rd_en`, `mem_wr_en`, `alu_start`, `cmd_done` = 0.
  - `mem_addr`, `mem_wdata`, `alu_opcode`, `alu_matrizA`, `alu_matrizB` = 0.
  - A reset mid-LOAD, mid-EXEC or mid-STORE aborts immediately. A partial write-back is left in memory.
- Cycle numbering: acceptance edge ends cycle 0.
  - Reads are issued in cycles 1..50.
  - Captures happen at edges ending cycles 2..51.
  - `alu_start` is high from cycle 52.
- For a 1-cycle ALU (`alu_done` high in cycle 53):
  - `alu_start` is low in cycle 54.
  - Writes occur in cycles 54..78.
  - `cmd_done` pulses in cycle 79.
  - `cmd_ready`=1 in cycle 80.
- Each extra ALU cycle adds 1 to the cycles from 54 onward.
- `alu_start` drops the cycle after `alu_done` is seen, so the ALU's `done` clears before the next command.

## Configuration
- Macro `MATRIX_LOADER_UNARY_SKIP_EN`.
- Defined: for opcodes 4'b0110 (transpose) and 4'b0111 (opposite), LOAD stops after k = 24 and B is forced to all zeros. `alu_start` then rises in cycle 27, not 52, and all later cycles shift by 25.
- Undefined: every opcode loads both A and B (50 reads).

## Test plan
- Sum: A = bytes 1..25 at 0x00, B = 0x10 at 0x40, opcode 0011, R = 0x80, 1-cycle ALU model -> memory 0x80..0x98 = 0x11..0x29; `cmd_done` in cycle 79.
- Wrap: `addr_a`=0xF0 -> reads hit 0xF0..0xFF then 0x00..0x08; element 16 taken from address 0x00.
- Slow ALU: `alu_done` delayed 10 cycles -> `alu_start` held continuously; `cmd_done` in cycle 88; exactly 25 writes.
- Back-pressure: `cmd_valid` held high during busy with changed addresses -> ignored; second command accepted only in cycle 80.
- Reset mid-STORE at write j=10 -> all outputs at reset values asynchronously; memory 0x8A onward untouched; next command runs normally.
- With `MATRIX_LOADER_UNARY_SKIP_EN`, opcode 0111 -> 25 reads only; `alu_matrizB`=0; `alu_start` rises in cycle 27.
